// File: rtl/sequence_generator.sv
// ---------------------------------------------------------------------------
// sequence_generator
//
// Transmit-side source for the 3-bit sequence detector. On a start request it
// drives the fixed 8-symbol frame 001,101,110,000,110,110,011,101 onto a
// 3-bit bus, one symbol per enabled cycle. It sends 1..16 frames with an
// optional idle gap between them and can corrupt the last symbol of each
// frame to 100.
//
// Parameters
//   GAP_CYCLES   enabled idle cycles inserted between consecutive frames
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (wins over every input)
//   start        send request, only honoured while idle
//   repeat_count frames to send minus one, captured at start
//   corrupt      captured at start; symbol 7 is sent as 100 instead of 101
//   enable       advance strobe; low stalls symbol and gap progress
//   data_out     current symbol (registered)
//   data_valid   data_out holds a frame symbol this cycle
//   busy         a transfer is in progress
//   frame_done   one-cycle pulse alongside symbol 7 of each frame
//   done         one-cycle pulse in the cycle after the final symbol
// ---------------------------------------------------------------------------
module sequence_generator #(
   parameter int GAP_CYCLES = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] repeat_count,
   input  logic       corrupt,
   input  logic       enable,
   output logic [2:0] data_out,
   output logic       data_valid,
   output logic       busy,
   output logic       frame_done,
   output logic       done
);

   // The gap counter must hold the value GAP_CYCLES; keep at least one bit so
   // the register exists even when gaps are disabled.
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
   localparam logic [2:0]    LAST_IDX = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t        state_reg,      state_next;
   logic [2:0]    idx_reg,        idx_next;
   logic [3:0]    frame_reg,      frame_next;
   logic [GW-1:0] gap_reg,        gap_next;
   logic [3:0]    rep_reg,        rep_next;
   logic          corrupt_reg,    corrupt_next;
   // Set on the edge that emits the final symbol; the following edge turns
   // it into the done pulse and drops busy.
   logic          finish_reg,     finish_next;

   logic [2:0]    data_out_reg,   data_out_next;
   logic          valid_reg,      valid_next;
   logic          busy_reg,       busy_next;
   logic          frame_done_reg, frame_done_next;
   logic          done_reg,       done_next;

   // Frame symbol table; only the last position depends on corruption.
   function automatic logic [2:0] sym_at(input logic [2:0] i, input logic corr);
      logic [2:0] s;
      case (i)
         3'd0:    s = 3'b001;
         3'd1:    s = 3'b101;
         3'd2:    s = 3'b110;
         3'd3:    s = 3'b000;
         3'd4:    s = 3'b110;
         3'd5:    s = 3'b110;
         3'd6:    s = 3'b011;
         default: s = corr ? 3'b100 : 3'b101;
      endcase
      return s;
   endfunction

   // -----------------------------------------------------------------------
   // State and output registers
   // -----------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         idx_reg        <= '0;
         frame_reg      <= '0;
         gap_reg        <= '0;
         rep_reg        <= '0;
         corrupt_reg    <= 1'b0;
         finish_reg     <= 1'b0;
         data_out_reg   <= 3'b000;
         valid_reg      <= 1'b0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         frame_reg      <= frame_next;
         gap_reg        <= gap_next;
         rep_reg        <= rep_next;
         corrupt_reg    <= corrupt_next;
         finish_reg     <= finish_next;
         data_out_reg   <= data_out_next;
         valid_reg      <= valid_next;
         busy_reg       <= busy_next;
         frame_done_reg <= frame_done_next;
         done_reg       <= done_next;
      end
   end

   // -----------------------------------------------------------------------
   // Next-state and next-output logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      frame_next      = frame_reg;
      gap_next        = gap_reg;
      rep_next        = rep_reg;
      corrupt_next    = corrupt_reg;
      finish_next     = 1'b0;
      data_out_next   = data_out_reg;
      valid_next      = 1'b0;
      busy_next       = busy_reg;
      frame_done_next = 1'b0;
      done_next       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (finish_reg) begin
               // Wrap-up edge after the last symbol; start is still ignored
               // here because busy is high during the last symbol cycle.
               done_next     = 1'b1;
               busy_next     = 1'b0;
               data_out_next = 3'b000;
            end else if (start) begin
               rep_next     = repeat_count;
               corrupt_next = corrupt;
               busy_next    = 1'b1;
               frame_next   = '0;
               gap_next     = '0;
               idx_next     = '0;
               state_next   = ST_SEND;
               if (enable) begin
                  // Symbol 0 goes out on the accepting edge itself.
                  data_out_next = sym_at(3'd0, corrupt);
                  valid_next    = 1'b1;
                  idx_next      = 3'd1;
               end
            end
         end

         ST_SEND: begin
            if (enable) begin
               data_out_next = sym_at(idx_reg, corrupt_reg);
               valid_next    = 1'b1;
               idx_next      = idx_reg + 3'd1;   // 7 wraps to 0 for the next frame
               if (idx_reg == LAST_IDX) begin
                  frame_done_next = 1'b1;
                  if (frame_reg == rep_reg) begin
                     state_next  = ST_IDLE;
                     finish_next = 1'b1;
                  end else begin
                     frame_next = frame_reg + 4'd1;
                     if (GAP_CYCLES > 0) begin
                        state_next = ST_GAP;
                        gap_next   = '0;
                     end
                  end
               end
            end
            // With enable low the symbol register holds and valid drops.
         end

         ST_GAP: begin
            data_out_next = 3'b000;
            if (enable) begin
               if (gap_reg == GAP_LAST) begin
                  // Gap fully counted: this edge already carries symbol 0.
                  data_out_next = sym_at(3'd0, corrupt_reg);
                  valid_next    = 1'b1;
                  idx_next      = 3'd1;
                  gap_next      = '0;
                  state_next    = ST_SEND;
               end else begin
                  gap_next = gap_reg + 1'b1;
               end
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign data_out   = data_out_reg;
   assign data_valid = valid_reg;
   assign busy       = busy_reg;
   assign frame_done = frame_done_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_sequence_generator.sv
// ---------------------------------------------------------------------------
// tb_sequence_generator
//
// Drives two instances in lockstep: one without inter-frame gap and one with
// a two-cycle gap. Every expected frame symbol is queued when a start is
// issued and popped when the instance raises data_valid.
// ---------------------------------------------------------------------------
module tb_sequence_generator;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] repeat_count = 4'd0;
   logic       corrupt = 1'b0;
   logic       enable = 1'b1;

   logic [2:0] dout0, dout1;
   logic       val0, val1, bsy0, bsy1, fd0, fd1, dn0, dn1;

   int checks = 0;
   int errors = 0;

   // per-instance counters, cleared at the start of each scenario
   int vcnt0, vcnt1, dcnt0, dcnt1, fcnt0, fcnt1, bcnt0, bcnt1;

   // scoreboard entries: {frame_done, data_out}
   logic [3:0] sb0[$];
   logic [3:0] sb1[$];

   logic [2:0] frame_sym [8] = '{3'b001, 3'b101, 3'b110, 3'b000,
                                 3'b110, 3'b110, 3'b011, 3'b101};

   always #5 clk = ~clk;

   sequence_generator #(.GAP_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .repeat_count(repeat_count),
      .corrupt(corrupt), .enable(enable), .data_out(dout0),
      .data_valid(val0), .busy(bsy0), .frame_done(fd0), .done(dn0)
   );

   sequence_generator #(.GAP_CYCLES(2)) dut1 (
      .clk(clk), .reset(reset), .start(start), .repeat_count(repeat_count),
      .corrupt(corrupt), .enable(enable), .data_out(dout1),
      .data_valid(val1), .busy(bsy1), .frame_done(fd1), .done(dn1)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_frame(input logic corr);
      for (int i = 0; i < 8; i++) begin
         logic [2:0] s;
         s = frame_sym[i];
         if (i == 7 && corr) s = 3'b100;
         sb0.push_back({(i == 7), s});
         sb1.push_back({(i == 7), s});
      end
   endtask

   task automatic clear_counts();
      vcnt0 = 0; vcnt1 = 0; dcnt0 = 0; dcnt1 = 0;
      fcnt0 = 0; fcnt1 = 0; bcnt0 = 0; bcnt1 = 0;
   endtask

   // Advance one clock, then sample both instances away from the edge.
   task automatic step();
      logic [3:0] e;
      @(posedge clk);
      #1;
      if (val0) begin
         vcnt0++;
         if (sb0.size() == 0) chk("unexpected_valid0", 8'(val0), 8'd0);
         else begin
            e = sb0.pop_front();
            chk("beat0", 8'({fd0, dout0}), 8'(e));
         end
      end
      chk("fd_without_valid0", 8'(fd0 & ~val0), 8'd0);
      chk("done_with_valid0", 8'(dn0 & val0), 8'd0);
      if (dn0) dcnt0++;
      if (fd0) fcnt0++;
      if (bsy0) bcnt0++;

      if (val1) begin
         vcnt1++;
         if (sb1.size() == 0) chk("unexpected_valid1", 8'(val1), 8'd0);
         else begin
            e = sb1.pop_front();
            chk("beat1", 8'({fd1, dout1}), 8'(e));
         end
      end
      chk("fd_without_valid1", 8'(fd1 & ~val1), 8'd0);
      chk("done_with_valid1", 8'(dn1 & val1), 8'd0);
      if (dn1) dcnt1++;
      if (fd1) fcnt1++;
      if (bsy1) bcnt1++;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_dout0"}, 8'(dout0), 8'd0);
      chk({tag, "_val0"},  8'(val0),  8'd0);
      chk({tag, "_busy0"}, 8'(bsy0),  8'd0);
      chk({tag, "_fd0"},   8'(fd0),   8'd0);
      chk({tag, "_done0"}, 8'(dn0),   8'd0);
      chk({tag, "_dout1"}, 8'(dout1), 8'd0);
      chk({tag, "_val1"},  8'(val1),  8'd0);
      chk({tag, "_busy1"}, 8'(bsy1),  8'd0);
      chk({tag, "_fd1"},   8'(fd1),   8'd0);
      chk({tag, "_done1"}, 8'(dn1),   8'd0);
   endtask

   // Single-frame scenario summary shared by several tests.
   task automatic chk_single(input string tag);
      chk({tag, "_valid_cnt0"}, 8'(vcnt0), 8'd8);
      chk({tag, "_valid_cnt1"}, 8'(vcnt1), 8'd8);
      chk({tag, "_fd_cnt0"},    8'(fcnt0), 8'd1);
      chk({tag, "_done_cnt0"},  8'(dcnt0), 8'd1);
      chk({tag, "_done_cnt1"},  8'(dcnt1), 8'd1);
      chk({tag, "_sb_left0"},   8'(sb0.size()), 8'd0);
      chk({tag, "_sb_left1"},   8'(sb1.size()), 8'd0);
   endtask

   initial begin
      // ---- reset state ----
      clear_counts();
      steps(2);
      chk_idle("reset");
      reset = 1'b0;
      step();
      chk_idle("post_reset");

      // ---- basic frame ----
      clear_counts();
      push_frame(1'b0);
      start = 1'b1; repeat_count = 4'd0; corrupt = 1'b0; enable = 1'b1;
      step();
      chk("basic_first_valid", 8'(val0), 8'd1);
      start = 1'b0;
      steps(7);
      chk("basic_busy_last_sym", 8'(bsy0), 8'd1);
      step();
      chk("basic_done", 8'(dn0), 8'd1);
      chk("basic_busy_off", 8'(bsy0), 8'd0);
      chk("basic_done_dout", 8'(dout0), 8'd0);
      steps(2);
      chk_single("basic");
      chk("basic_busy_cycles", 8'(bcnt0), 8'd8);

      // ---- corrupt, with corrupt dropped while busy ----
      clear_counts();
      push_frame(1'b1);
      start = 1'b1; corrupt = 1'b1;
      step();
      start = 1'b0; corrupt = 1'b0;
      steps(10);
      chk_single("corrupt");

      // ---- two frames: back-to-back on dut0, 2-cycle gap on dut1 ----
      clear_counts();
      push_frame(1'b0);
      push_frame(1'b0);
      start = 1'b1; repeat_count = 4'd1;
      step();
      start = 1'b0; repeat_count = 4'd5;   // must not affect the running transfer
      steps(7);
      for (int g = 0; g < 2; g++) begin
         step();
         chk("gap_valid1", 8'(val1), 8'd0);
         chk("gap_dout1", 8'(dout1), 8'd0);
         chk("gap_busy1", 8'(bsy1), 8'd1);
         chk("nogap_valid0", 8'(val0), 8'd1);
      end
      step();
      chk("gap_resume_valid1", 8'(val1), 8'd1);
      steps(9);
      chk("rep_valid_cnt0", 8'(vcnt0), 8'd16);
      chk("rep_valid_cnt1", 8'(vcnt1), 8'd16);
      chk("rep_fd_cnt0", 8'(fcnt0), 8'd2);
      chk("rep_fd_cnt1", 8'(fcnt1), 8'd2);
      chk("rep_done_cnt0", 8'(dcnt0), 8'd1);
      chk("rep_done_cnt1", 8'(dcnt1), 8'd1);
      chk("rep_busy_cycles0", 8'(bcnt0), 8'd16);
      chk("rep_busy_cycles1", 8'(bcnt1), 8'd18);
      chk("rep_sb_left0", 8'(sb0.size()), 8'd0);
      chk("rep_sb_left1", 8'(sb1.size()), 8'd0);
      repeat_count = 4'd0;

      // ---- stall after symbol 110 ----
      clear_counts();
      push_frame(1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      steps(2);
      enable = 1'b0;
      for (int s = 0; s < 3; s++) begin
         step();
         chk("stall_valid0", 8'(val0), 8'd0);
         chk("stall_hold0", 8'(dout0), 8'b110);
      end
      enable = 1'b1;
      step();
      chk("stall_resume0", 8'(dout0), 8'b000);
      steps(6);
      chk_single("stall");

      // ---- reset after three symbols ----
      clear_counts();
      push_frame(1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      steps(2);
      sb0.delete();
      sb1.delete();
      reset = 1'b1;
      step();
      chk_idle("midreset");
      reset = 1'b0;
      steps(3);
      chk("midreset_no_done0", 8'(dcnt0), 8'd0);
      chk("midreset_no_done1", 8'(dcnt1), 8'd0);
      clear_counts();
      push_frame(1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      steps(9);
      chk_single("restart");

      // ---- start held while busy is ignored ----
      clear_counts();
      push_frame(1'b0);
      start = 1'b1;
      steps(4);
      start = 1'b0;
      steps(6);
      chk_single("start_busy");

      // ---- start in the done cycle begins a new frame ----
      clear_counts();
      push_frame(1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      steps(8);
      chk("done_cycle_done0", 8'(dn0), 8'd1);
      push_frame(1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("done_cycle_restart_dout0", 8'(dout0), 8'b001);
      chk("done_cycle_restart_valid0", 8'(val0), 8'd1);
      steps(9);
      chk("done_cycle_done_cnt0", 8'(dcnt0), 8'd2);
      chk("done_cycle_valid_cnt0", 8'(vcnt0), 8'd16);
      chk("done_cycle_sb_left0", 8'(sb0.size()), 8'd0);

      // ---- start and reset on the same edge ----
      clear_counts();
      reset = 1'b1; start = 1'b1;
      step();
      chk_idle("start_reset");
      reset = 1'b0; start = 1'b0;
      steps(3);
      chk_idle("start_reset_after");
      chk("start_reset_valid_cnt0", 8'(vcnt0), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
